lcg_stim_sequencer: RTL and testbench

Synthesizable stimulus controller for the fuzz DUT `top` (flat `in_flat` / `out_flat` interface). On `start` it drives the DUT reset, then generates a deterministic vector sequence with the team's LCG and applies each vector to `in_flat`. It counts applied vectors and signals completion. The sequence is bit-identical across simulators, so dual-sim runs stay comparable, and it can run in emulation without a behavioural testbench.

---
 rtl/lcg_stim_pkg.sv | 27 ++
 rtl/lcg_stim_misr.sv | 41 ++++
 rtl/lcg_stim_sequencer.sv | 131 +++++++++++++
 tb/tb_lcg_stim_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcg_stim_pkg.sv
// Shared constants, state encoding and helpers for the LCG stimulus sequencer.
package lcg_stim_pkg;

  localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC = 32'h3039;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    FILL,
    APPLY,
    DONE
  } state_t;

  // One LCG step, arithmetic modulo 2^32.
  function automatic logic [31:0] lcg_step(input logic [31:0] r);
    logic [31:0] prod;
    prod = r * LCG_MUL;
    return prod + LCG_INC;
  endfunction

  // Number of 32-bit words needed to cover a vector of width w.
  function automatic int unsigned nwords(input int unsigned w);
    return (w + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/lcg_stim_misr.sv
// 32-bit MISR compacting the DUT response; built only with LCG_STIM_SIG_MISR_EN.
module lcg_stim_misr
  import lcg_stim_pkg::*;
#(
  parameter int unsigned OUT_W = 159
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] data,
  output logic [31:0]      sig
);

  localparam int unsigned NCH = nwords(OUT_W);

  logic [NCH*32-1:0] padded;
  logic [31:0]       fold;

  // XOR-fold the response into one word; the last chunk is zero-padded.
  always_comb begin
    padded = '0;
    padded[OUT_W-1:0] = data;
    fold = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      fold = fold ^ padded[k*32 +: 32];
    end
  end

  // Signature register: cleared on run start, shifted and folded on each apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ fold;
    end
  end

endmodule

// File: rtl/lcg_stim_sequencer.sv
// LCG-driven stimulus sequencer for the flat-interface fuzz DUT.
// Optional response signature: define LCG_STIM_SIG_MISR_EN.
module lcg_stim_sequencer
  import lcg_stim_pkg::*;
#(
  parameter int unsigned IN_W    = 138,
  parameter int unsigned OUT_W   = 159,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned RST_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] cycles,
  output logic             busy,
  output logic             done,
  output logic             dut_rst_n,
  output logic [IN_W-1:0]  in_flat,
  output logic             in_valid,
  input  logic [OUT_W-1:0] out_flat,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [31:0]      signature
);

  localparam int unsigned NW        = nwords(IN_W);
  localparam int unsigned LAST_BITS = IN_W - (NW - 1) * 32;

  state_t            state, state_next;
  logic [31:0]       rng;
  logic [31:0]       word;
  logic [31:0]       widx;
  logic [31:0]       rst_cnt;
  logic [IN_W-1:0]   shadow;
  logic [CNT_W-1:0]  cycles_q;
  // One extra bit so cycles = all-ones still terminates after 2^CNT_W vectors.
  logic [CNT_W:0]    vec_cnt_q;
  logic [CNT_W:0]    cnt_inc;
  logic [CNT_W:0]    cyc_end;
  logic              accept;

  assign accept  = (state == IDLE) && start;
  assign word    = lcg_step(rng);
  assign cnt_inc = vec_cnt_q + 1'b1;
  assign cyc_end = {1'b0, cycles_q} + 1'b1;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign vec_cnt = vec_cnt_q[CNT_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RST;
      RST:     if (rst_cnt == RST_CYC - 1) state_next = FILL;
      FILL:    if (widx == NW - 1) state_next = APPLY;
      APPLY:   state_next = (cnt_inc == cyc_end) ? DONE : FILL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: run setup, DUT reset, shadow fill and vector application.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_rst_n <= 1'b0;
      in_flat   <= '0;
      in_valid  <= 1'b0;
      rng       <= '0;
      widx      <= '0;
      rst_cnt   <= '0;
      shadow    <= '0;
      cycles_q  <= '0;
      vec_cnt_q <= '0;
    end else begin
      dut_rst_n <= (state_next != RST);
      in_valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            rng       <= seed;
            cycles_q  <= cycles;
            vec_cnt_q <= '0;
            rst_cnt   <= '0;
            widx      <= '0;
          end
        end
        RST: rst_cnt <= rst_cnt + 1'b1;
        FILL: begin
          rng  <= word;
          widx <= widx + 1'b1;
          for (int unsigned k = 0; k + 1 < NW; k++) begin
            if (widx == k) shadow[k*32 +: 32] <= word;
          end
          if (widx == NW - 1) shadow[IN_W-1 -: LAST_BITS] <= word[LAST_BITS-1:0];
        end
        APPLY: begin
          in_flat   <= shadow;
          in_valid  <= 1'b1;
          vec_cnt_q <= cnt_inc;
          widx      <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef LCG_STIM_SIG_MISR_EN
  lcg_stim_misr #(
    .OUT_W (OUT_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == APPLY),
    .data  (out_flat),
    .sig   (signature)
  );
`else
  logic out_flat_unused;
  assign out_flat_unused = ^out_flat;
  assign signature       = '0;
`endif

endmodule

// File: tb/tb_lcg_stim_sequencer.sv
// Self-checking bench for lcg_stim_sequencer against a behavioural LCG model.
module tb_lcg_stim_sequencer;

  localparam int unsigned IW  = 138;
  localparam int unsigned OW  = 159;
  localparam int unsigned NWD = (IW + 31) / 32;
  localparam int unsigned RC  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   seed = '0;
  logic [31:0]   cycles = '0;
  logic          busy, done, dut_rst_n, in_valid;
  logic [IW-1:0] in_flat;
  logic [OW-1:0] out_flat = '0;
  logic [31:0]   vec_cnt, signature;

  logic          start2 = 1'b0;
  logic [31:0]   seed2 = '0;
  logic [3:0]    cycles2 = '0;
  logic          busy2, done2, dut_rst_n2, in_valid2;
  logic [IW-1:0] in_flat2;
  logic [OW-1:0] out_flat2 = '0;
  logic [3:0]    vec_cnt2;
  logic [31:0]   signature2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcg_stim_sequencer #(.IN_W(IW), .OUT_W(OW), .CNT_W(32), .RST_CYC(RC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .cycles(cycles),
    .busy(busy), .done(done), .dut_rst_n(dut_rst_n), .in_flat(in_flat),
    .in_valid(in_valid), .out_flat(out_flat), .vec_cnt(vec_cnt), .signature(signature)
  );

  lcg_stim_sequencer #(.IN_W(IW), .OUT_W(OW), .CNT_W(4), .RST_CYC(RC)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .cycles(cycles2),
    .busy(busy2), .done(done2), .dut_rst_n(dut_rst_n2), .in_flat(in_flat2),
    .in_valid(in_valid2), .out_flat(out_flat2), .vec_cnt(vec_cnt2), .signature(signature2)
  );

  // Vector n (1-based) of a run: n*NWD consecutive LCG outputs, the last NWD packed low word first.
  function automatic logic [IW-1:0] model_vec(input logic [31:0] s, input int unsigned n);
    logic [31:0]       r;
    logic [NWD*32-1:0] acc;
    r = s;
    acc = '0;
    for (int unsigned i = 0; i < n * NWD; i++) begin
      r = r * 32'd1103515245 + 32'd12345;
      acc[(i % NWD)*32 +: 32] = r;
    end
    return acc[IW-1:0];
  endfunction

  function automatic logic [31:0] model_sig(input logic [OW-1:0] d, input int unsigned nvec);
    logic [191:0] p;
    logic [31:0]  f, sg;
    p = '0;
    p[OW-1:0] = d;
    f = '0;
    for (int k = 0; k < 6; k++) f = f ^ p[k*32 +: 32];
    sg = '0;
    for (int unsigned v = 0; v < nvec; v++)
      sg = {sg[30:0], sg[31] ^ sg[21] ^ sg[1] ^ sg[0]} ^ f;
    return sg;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] s, input logic [31:0] c);
    seed = s;
    cycles = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Follows a run from the sample just after start acceptance, checking every vector.
  task automatic follow_run(input string name, input logic [31:0] s, input int unsigned c,
                            input int unsigned abort_at, output int unsigned nv_out);
    int unsigned nv, budget, exp_t, last_t;
    logic [31:0] exp_sig;
    bit fin;
    nv = 0;
    fin = 1'b0;
    last_t = 0;
    budget = (c + 1) * (NWD + 1) + RC + 20;
    checks++;
    if ({busy, dut_rst_n, done, in_valid} !== 4'b1000 || vec_cnt !== 0) begin
      errors++;
      $display("FAIL %s_accept busy/rst_n/done/valid=%b vec_cnt=%0d required 1000 and 0",
               name, {busy, dut_rst_n, done, in_valid}, vec_cnt);
    end
    for (int unsigned t = 1; t <= budget && !fin; t++) begin
      tick();
      if (t <= RC) begin
        checks++;
        if (dut_rst_n !== (t >= RC)) begin
          errors++;
          $display("FAIL %s_dut_rst_n t=%0d got %b required %b", name, t, dut_rst_n, (t >= RC));
        end
      end
      if (in_valid === 1'b1) begin
        nv++;
        exp_t = RC + NWD + 1 + (nv - 1) * (NWD + 1);
        checks++;
        if (t != exp_t) begin
          errors++;
          $display("FAIL %s_timing vec %0d at clock %0d required %0d", name, nv, t, exp_t);
        end
        checks++;
        if (in_flat !== model_vec(s, nv)) begin
          errors++;
          $display("FAIL %s_vector %0d got %h required %h", name, nv, in_flat, model_vec(s, nv));
        end
        checks++;
        if (vec_cnt !== nv) begin
          errors++;
          $display("FAIL %s_vec_cnt got %0d required %0d", name, vec_cnt, nv);
        end
        last_t = t;
        if (abort_at != 0 && nv == abort_at) begin
          nv_out = nv;
          return;
        end
      end
      if (done === 1'b1) begin
        fin = 1'b1;
        checks++;
        if (nv != c + 1 || last_t != t) begin
          errors++;
          $display("FAIL %s_done vectors %0d last at %0d done at %0d required %0d vectors, same clock",
                   name, nv, last_t, t, c + 1);
        end
      end
    end
    nv_out = nv;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout no done after %0d clocks, %0d vectors seen", name, budget, nv);
      return;
    end
    tick();
`ifdef LCG_STIM_SIG_MISR_EN
    exp_sig = model_sig(out_flat, c + 1);
`else
    exp_sig = '0;
`endif
    checks++;
    if ({busy, done, in_valid, dut_rst_n} !== 4'b0001 || in_flat !== model_vec(s, c + 1) ||
        vec_cnt !== c + 1) begin
      errors++;
      $display("FAIL %s_hold busy/done/valid/rst_n=%b vec_cnt=%0d required 0001 and %0d",
               name, {busy, done, in_valid, dut_rst_n}, vec_cnt, c + 1);
    end
    checks++;
    if (signature !== exp_sig) begin
      errors++;
      $display("FAIL %s_signature got %h required %h", name, signature, exp_sig);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, dut_rst_n, in_valid} !== 4'b0000 || in_flat !== '0 || vec_cnt !== 0 ||
        signature !== 0) begin
      errors++;
      $display("FAIL reset_values busy/done/rst_n/valid=%b in_flat=%h vec_cnt=%0d sig=%h required all 0",
               {busy, done, dut_rst_n, in_valid}, in_flat, vec_cnt, signature);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (dut_rst_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset dut_rst_n=%b busy=%b required 1 and 0", dut_rst_n, busy);
    end
  endtask

  task automatic test_seed_zero();
    int unsigned nv;
    logic [31:0] w0, w1;
    start_run(32'd0, 32'd0);
    follow_run("seed0", 32'd0, 0, 0, nv);
    w0 = in_flat[31:0];
    w1 = in_flat[63:32];
    checks++;
    if (w0 !== 32'h00003039 || w1 !== 32'hD3DC167E) begin
      errors++;
      $display("FAIL seed0_words got %h %h required 00003039 d3dc167e", w0, w1);
    end
  endtask

  task automatic test_long_run();
    int unsigned nv;
    start_run(32'd784456416, 32'd150);
    follow_run("long", 32'd784456416, 150, 0, nv);
  endtask

  task automatic test_random_runs();
    int unsigned nv, c;
    logic [31:0] s;
    for (int i = 0; i < 4; i++) begin
      s = $urandom;
      c = $urandom_range(0, 5);
      start_run(s, c);
      follow_run("random", s, c, 0, nv);
    end
  endtask

  task automatic test_restart_ignored();
    logic [31:0] sa, sb;
    int unsigned nv;
    bit fin;
    sa = $urandom;
    sb = $urandom;
    nv = 0;
    fin = 1'b0;
    start_run(sa, 32'd2);
    start = 1'b1;
    seed = sb;
    cycles = 32'd7;
    for (int t = 0; t < 60 && !fin; t++) begin
      tick();
      if (in_valid === 1'b1) begin
        nv++;
        checks++;
        if (in_flat !== model_vec(sa, nv)) begin
          errors++;
          $display("FAIL restart_vector %0d got %h required %h", nv, in_flat, model_vec(sa, nv));
        end
      end
      if (done === 1'b1) fin = 1'b1;
    end
    checks++;
    if (!fin || nv != 3) begin
      errors++;
      $display("FAIL restart_count done=%b vectors=%0d required 1 and 3", fin, nv);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || vec_cnt !== 3 || in_flat !== model_vec(sa, 3)) begin
      errors++;
      $display("FAIL restart_at_done busy=%b vec_cnt=%0d required 0 and 3", busy, vec_cnt);
    end
    tick();
    start = 1'b0;
    follow_run("restart_new", sb, 7, 0, nv);
  endtask

  task automatic test_abort();
    logic [31:0] s;
    int unsigned nv;
    s = $urandom;
    start_run(s, 32'd150);
    follow_run("abort", s, 150, 40, nv);
    checks++;
    if (nv != 40) begin
      errors++;
      $display("FAIL abort_reach vectors=%0d required 40", nv);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, dut_rst_n, in_valid} !== 4'b0000 || in_flat !== '0 || vec_cnt !== 0 ||
        signature !== 0) begin
      errors++;
      $display("FAIL abort_async busy/done/rst_n/valid=%b in_flat=%h vec_cnt=%0d required all 0",
               {busy, done, dut_rst_n, in_valid}, in_flat, vec_cnt);
    end
    #1 rst_n = 1'b1;
    tick();
    start_run(s, 32'd0);
    follow_run("abort_rerun", s, 0, 0, nv);
  endtask

  task automatic test_signature();
    int unsigned nv;
    logic [31:0] s;
    s = $urandom;
    out_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
    start_run(s, 32'd4);
    follow_run("sig_rand", s, 4, 0, nv);
    out_flat = '0;
    start_run(s, 32'd3);
    follow_run("sig_zero", s, 3, 0, nv);
  endtask

  task automatic test_max_cycles();
    logic [31:0] s;
    int unsigned nv;
    bit fin;
    s = $urandom;
    nv = 0;
    fin = 1'b0;
    seed2 = s;
    cycles2 = 4'hF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int t = 0; t < 16 * (NWD + 1) + 20 && !fin; t++) begin
      tick();
      if (in_valid2 === 1'b1) begin
        nv++;
        checks++;
        if (in_flat2 !== model_vec(s, nv) || vec_cnt2 !== nv[3:0]) begin
          errors++;
          $display("FAIL max_vector %0d got %h cnt %0d required %h cnt %0d",
                   nv, in_flat2, vec_cnt2, model_vec(s, nv), nv[3:0]);
        end
      end
      if (done2 === 1'b1) fin = 1'b1;
    end
    checks++;
    if (!fin || nv != 16) begin
      errors++;
      $display("FAIL max_count done=%b vectors=%0d required 1 and 16", fin, nv);
    end
    tick();
    checks++;
    if (busy2 !== 1'b0 || dut_rst_n2 !== 1'b1 || signature2 !== 0 || vec_cnt2 !== 4'd0) begin
      errors++;
      $display("FAIL max_idle busy=%b rst_n=%b sig=%h cnt=%0d required 0 1 0 0",
               busy2, dut_rst_n2, signature2, vec_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_seed_zero();
    test_long_run();
    test_random_runs();
    test_restart_ignored();
    test_abort();
    test_signature();
    test_max_cycles();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
